// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the EX stage of the pipelined MIPS core.
//
// Executes mult/multu/div/divu with a fixed multi-cycle latency, handles
// mthi/mtlo immediately, and holds the architectural HI/LO registers read by
// mfhi/mflo. The hazard unit watches busy_o to stall decode while an operation
// is in flight.
//
// The result is computed combinationally from the forwarded operands in the
// start cycle and parked in pend_hi/pend_lo. The busy period is pure latency
// modelling: HI/LO only change when the counter expires.
//
// Ports:
//   clk_i      core clock, all state updates on the rising edge
//   reset_i    synchronous, active-high reset
//   start_i    qualifies md_op_i this cycle
//   md_op_i    0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 no-op
//   src_a_i    forwarded rs value
//   src_b_i    forwarded rt value
//   busy_o     operation in flight (registered, equals state RUN)
//   hi_o       architectural HI
//   lo_o       architectural LO
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [2:0]  md_op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;

    // Combinational result for the operation presented this cycle.
    logic [31:0] res_hi_d, res_lo_d;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;

    // One shared magnitude divider serves both div and divu; signed division
    // divides magnitudes and fixes the signs afterwards, which also makes
    // 0x80000000 / -1 well defined (quotient wraps to 0x80000000, rem 0).
    logic        is_signed_div;
    logic        neg_a, neg_b;
    logic [31:0] div_num, div_den;
    logic [31:0] quo_mag, rem_mag;

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first so no
        // path through the case statements can leave a latch behind.
        res_hi_d      = hi_q;
        res_lo_d      = lo_q;
        is_signed_div = (md_op_i == OP_DIV);
        neg_a         = is_signed_div && src_a_i[31];
        neg_b         = is_signed_div && src_b_i[31];
        div_num       = neg_a ? (32'd0 - src_a_i) : src_a_i;
        div_den       = neg_b ? (32'd0 - src_b_i) : src_b_i;
        // Divisor forced to 1 on divide-by-zero only to keep the divider
        // defined; that result is discarded below.
        if (src_b_i == 32'd0) begin
            div_den = 32'd1;
        end
        quo_mag = div_num / div_den;
        rem_mag = div_num % div_den;

        prod_s = $signed({{32{src_a_i[31]}}, src_a_i}) * $signed({{32{src_b_i[31]}}, src_b_i});
        prod_u = {32'd0, src_a_i} * {32'd0, src_b_i};

        case (md_op_i)
            OP_MULT: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                // Divide by zero keeps the current HI/LO (defaults above).
                if (src_b_i != 32'd0) begin
                    res_lo_d = (neg_a ^ neg_b) ? (32'd0 - quo_mag) : quo_mag;
                    res_hi_d = neg_a ? (32'd0 - rem_mag) : rem_mag;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        case (md_op_i)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_q <= res_hi_d;
                                pend_lo_q <= res_lo_d;
                                cnt_q     <= MULT_CNT;
                                state_q   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_q <= res_hi_d;
                                pend_lo_q <= res_lo_d;
                                cnt_q     <= DIV_CNT;
                                state_q   <= RUN;
                            end
                            OP_MTHI: hi_q <= src_a_i;
                            OP_MTLO: lo_q <= src_a_i;
                            default: begin
                            end
                        endcase
                    end
                end
                RUN: begin
                    // Any start_i here is ignored, mthi/mtlo included.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == RUN);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule
